// File: rtl/adder_seq_pkg.sv
// Shared types for the multi-precision add/subtract sequencer.
package adder_seq_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/adder_n_cla.sv
// N-bit adder with carry-in, using a parallel-prefix (Kogge-Stone) carry tree.
module adder_n_cla #(
   parameter int N = 32
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic         c_in_i,
   output logic [N-1:0] sum_o,
   output logic         c_out_o
);

   localparam int LVLS = (N > 1) ? $clog2(N) : 0;

   logic [N-1:0] p_bit;
   logic [N-1:0] g_pre;
   logic [N-1:0] p_pre;
   logic [N-1:0] c_vec;

   always_comb begin
      p_bit = a_i ^ b_i;
      g_pre = a_i & b_i;
      p_pre = p_bit;
      // Fold the carry-in into bit 0 so the prefix result is the carry out of each bit.
      g_pre[0] = g_pre[0] | (p_bit[0] & c_in_i);
      for (int lvl = 0; lvl < LVLS; lvl++) begin
         for (int i = N - 1; i >= (1 << lvl); i--) begin
            g_pre[i] = g_pre[i] | (p_pre[i] & g_pre[i - (1 << lvl)]);
            p_pre[i] = p_pre[i] & p_pre[i - (1 << lvl)];
         end
      end
      c_vec    = {g_pre[N-2:0], c_in_i};
      sum_o    = p_bit ^ c_vec;
      c_out_o  = g_pre[N-1];
   end

endmodule

// File: rtl/adder_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one N-bit adder reused word by word, LSW first.
module adder_seq_ctrl
   import adder_seq_pkg::*;
#(
   parameter int N     = 32,
   parameter int WORDS = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WORDS*N-1:0] in_a,
   input  logic [WORDS*N-1:0] in_b,
   input  logic               in_sub,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WORDS*N-1:0] out_sum,
   output logic               out_cout,
   output logic               out_ovf,
   output logic               busy
);

   localparam int OP_W  = WORDS * N;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // ready and valid are decoded from registered state only.
   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q,   idx_d;
   logic              carry_q, carry_d;
   logic [OP_W-1:0]   a_q,     a_d;
   logic [OP_W-1:0]   b_q,     b_d;
   logic              sub_q,   sub_d;
   logic [OP_W-1:0]   sum_q,   sum_d;
   logic              cout_q,  cout_d;
   logic              ovf_q,   ovf_d;

   logic [N-1:0]      a_word;
   logic [N-1:0]      b_word;
   logic [N-1:0]      add_sum;
   logic              add_cout;

   assign a_word = a_q[idx_q * N +: N];
   assign b_word = b_q[idx_q * N +: N] ^ {N{sub_q}};

   adder_n_cla #(.N(N)) u_adder (
      .a_i     (a_word),
      .b_i     (b_word),
      .c_in_i  (carry_q),
      .sum_o   (add_sum),
      .c_out_o (add_cout)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sub_d   = sub_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               sub_d   = in_sub;
               idx_d   = '0;
               carry_d = in_sub;
               sum_d   = '0;
               cout_d  = 1'b0;
               ovf_d   = 1'b0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            sum_d[idx_q * N +: N] = add_sum;
            carry_d               = add_cout;
            if (idx_q == LAST_IDX) begin
               cout_d  = add_cout;
               // Signed overflow: operands share a sign that the top word's result does not.
               ovf_d   = (a_word[N-1] == b_word[N-1]) && (add_sum[N-1] != a_word[N-1]);
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sub_q   <= sub_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;
   assign out_ovf   = ovf_q;

endmodule
